// File: rtl/bcd_serial_addsub_ctrl_if.sv
// Request/response bundle for the digit-serial BCD add/subtract controller.
// The requester drives the operands and start; the controller returns status and result.
interface bcd_serial_addsub_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  op;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  carry_out;
    logic                  negative;
    logic                  error;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry_out, negative, error
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry_out, negative, error
    );
endinterface

// File: rtl/bcd_serial_addsub_ctrl.sv
// Sequencer that time-shares one BCD add/subtract digit slice across DIGITS digits,
// LSD first, with a recomplement pass so negative differences come out as sign-magnitude.
module bcd_serial_addsub_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    bcd_serial_addsub_ctrl_if.slave   bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t             state;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       result_r;
    logic               op_r;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               busy_r;
    logic               done_r;
    logic               cout_r;
    logic               neg_r;
    logic               err_r;

    logic [3:0]         x_d;
    logic [3:0]         y_d;
    logic [4:0]         slice;

    function automatic logic [3:0] nines(input logic [3:0] d);
        return 4'd9 - d;
    endfunction

    // Binary add followed by +6 correction; bit 4 of the return is the decimal carry.
    function automatic logic [4:0] bcd_slice(input logic [3:0] x, input logic [3:0] y,
                                             input logic cin);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (s > 5'd9)
            return {1'b1, s[3:0] + 4'd6};
        return {1'b0, s[3:0]};
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[i*4 +: 4] > 4'd9)
                return 1'b1;
        return 1'b0;
    endfunction

    always_comb begin
        x_d = 4'd0;
        y_d = 4'd0;
        if (state == PASS2) begin
            y_d = nines(result_r[int'(idx)*4 +: 4]);
        end else begin
            x_d = a_r[int'(idx)*4 +: 4];
            y_d = op_r ? nines(b_r[int'(idx)*4 +: 4]) : b_r[int'(idx)*4 +: 4];
        end
        slice = bcd_slice(x_d, y_d, carry);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= 1'b0;
            result_r <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cout_r   <= 1'b0;
            neg_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        op_r     <= bus.op;
                        idx      <= '0;
                        carry    <= bus.op;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                        neg_r    <= 1'b0;
                        err_r    <= has_bad_digit(bus.a) || has_bad_digit(bus.b);
                        busy_r   <= 1'b1;
                        state    <= PASS1;
                    end else begin
                        state <= IDLE;
                    end
                end
                PASS1: begin
                    // A flagged operand skips the arithmetic and completes on this edge.
                    if (err_r) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        result_r[int'(idx)*4 +: 4] <= slice[3:0];
                        carry <= slice[4];
                        if (idx == LAST) begin
                            idx <= '0;
                            if (op_r && !slice[4]) begin
                                neg_r <= 1'b1;
                                carry <= 1'b1;
                                state <= PASS2;
                            end else begin
                                cout_r <= !op_r && slice[4];
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                                state  <= DONE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PASS2: begin
                    result_r[int'(idx)*4 +: 4] <= slice[3:0];
                    carry <= slice[4];
                    if (idx == LAST) begin
                        idx    <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.carry_out = cout_r;
    assign bus.negative  = neg_r;
    assign bus.error     = err_r;
endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Bench for bcd_serial_addsub_ctrl: directed cases with literal expectations, then random
// operations scored against a decimal-arithmetic model with per-cycle busy/done checks.
module tb_bcd_serial_addsub_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_serial_addsub_ctrl_if #(.DIGITS(DIGITS)) bus ();
    bcd_serial_addsub_ctrl #(.DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int           e0;
        int           dc;
        logic [W-1:0] res;
        logic         co;
        logic         neg;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   hold        = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic bit bad_bcd(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int n = 0;
        for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(v[i*4 +: 4]);
        return n;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] v = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return v;
    endfunction

    // Decimal reference: plain integer add/subtract on the operand values.
    task automatic model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output bit co, output bit neg,
                         output bit err, output int lat);
        int av, bv, lim;
        lim = 10 ** DIGITS;
        r = '0; co = 1'b0; neg = 1'b0; err = 1'b0; lat = DIGITS;
        if (bad_bcd(a) || bad_bcd(b)) begin
            err = 1'b1;
            lat = 1;
        end else begin
            av = bcd2int(a);
            bv = bcd2int(b);
            if (!op) begin
                r  = int2bcd((av + bv) % lim);
                co = (av + bv) >= lim;
            end else if (av >= bv) begin
                r = int2bcd(av - bv);
            end else begin
                r   = int2bcd(bv - av);
                neg = 1'b1;
                lat = 2 * DIGITS;
            end
        end
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        int k;
        for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 9) == 0) begin
            k = int'($urandom_range(0, DIGITS - 1));
            v[k*4 +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!hold) begin
            if (q.size() > 0 && cyc >= q[0].e0) begin
                if (cyc < q[0].dc) begin
                    chk("busy_during_op", W'({bus.busy, bus.done}), W'(2'b10));
                end else begin
                    chk("done_pulse", W'({bus.busy, bus.done}), W'(2'b01));
                    chk("result", bus.result, q[0].res);
                    chk("cout_neg_err", W'({bus.carry_out, bus.negative, bus.error}),
                        W'({q[0].co, q[0].neg, q[0].err}));
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_busy_done", W'({bus.busy, bus.done}), W'(2'b00));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; returns just after the edge that should raise done.
    task automatic go(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input bit co, input bit neg, input bit err,
                      input int lat, input bit glitch);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.e0 = cyc + 1;
        e.dc = cyc + 1 + lat;
        e.res = res; e.co = co; e.neg = neg; e.err = err;
        q.push_back(e);
        tick();
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        if (glitch && (e.dc - cyc) >= 2) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        while (cyc < e.dc) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb, rr;
        bit rop, rco, rneg, rerr;
        int rlat;

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) tick();
        chk("reset_busy_done", W'({bus.busy, bus.done}), W'(2'b00));
        chk("reset_result", bus.result, '0);
        chk("reset_flags", W'({bus.carry_out, bus.negative, bus.error}), W'(3'b000));
        reset = 1'b0;
        hold  = 1'b0;
        tick();

        go(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        repeat (2) tick();
        go(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 1'b0);
        go(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        go(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        go(1'b1, 16'h0042, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        go(1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 1'b0, 8, 1'b0);
        go(1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        go(1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        go(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        tick();

        // Abort a negative subtract in its recomplement pass.
        hold      = 1'b1;
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h5000;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("busy_before_abort", W'({bus.busy, bus.done}), W'(2'b10));
        reset = 1'b1;
        q.delete();
        tick();
        chk("abort_busy_done", W'({bus.busy, bus.done}), W'(2'b00));
        chk("abort_result", bus.result, '0);
        chk("abort_flags", W'({bus.carry_out, bus.negative, bus.error}), W'(3'b000));
        reset = 1'b0;
        hold  = 1'b0;
        repeat (10) tick();
        go(1'b0, 16'h0123, 16'h0877, 16'h1000, 1'b0, 1'b0, 1'b0, 4, 1'b0);

        for (int n = 0; n < 300; n++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = rand_bcd(1'b1);
            rb  = rand_bcd(1'b1);
            if ($urandom_range(0, 7) == 0) rb = ra;
            model(rop, ra, rb, rr, rco, rneg, rerr, rlat);
            go(rop, ra, rb, rr, rco, rneg, rerr, rlat, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_ops: got %0d outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_serial_addsub_ctrl.md
# bcd_serial_addsub_ctrl

Digit-serial controller for multi-digit signed BCD addition and subtraction. It time-shares a single one-digit BCD add/subtract slice (9's-complement mux, binary add, +6 correction) across DIGITS digits, least-significant digit first. For a negative difference it runs a second recomplement pass on the same slice, so the output is always sign-magnitude. It sits above the one-digit BCD adder/subtractor as its sequencer.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset; synchronous and active-high
- start  in  1  request; accepted only when busy=0
- op  in  1  0 = add (a+b), 1 = subtract (a−b); sampled with start
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]; sampled with start
- b  in  4*DIGITS  operand B, same format; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  4*DIGITS  BCD sum, or magnitude of the difference
- carry_out  out  1  add: carry out of the top digit; always 0 for subtract
- negative  out  1  subtract: 1 when a<b; always 0 for add
- error  out  1  an operand held a digit >9

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE, start=1:
  - Register a, b and op. Set digit index to 0 and carry to op. Clear error and negative.
  - If any digit of a or b is >9: go to DONE with error=1 and result=0. No pass runs.
  - Otherwise go to PASS1.
- PASS1, one digit per cycle:
  - Slice inputs are x = a[i] and y = op ? 9's(b[i]) : b[i], plus the carry register. 9's(d) = 9−d.
  - Write the slice sum to result[i]. Load the slice decimal carry into the carry register.
  - After digit DIGITS−1:
    - If op=0: carry_out = final carry; go to DONE.
    - If op=1 and final carry=1: the result is the difference, negative=0; go to DONE.
    - If op=1 and final carry=0: negative=1; go to PASS2.
- PASS2 (recomplement):
  - Set index to 0 and carry to 1.
  - Per digit: x = 0 and y = 9's(result[i]). Write the slice sum back to result[i].
  - After the last digit, go to DONE. The PASS2 final carry is discarded.
- DONE: assert done for one cycle, deassert busy, return to IDLE.
- Arithmetic rules:
  - Slice sum = x + y + cin, range 0..19. The decimal carry is 1 when the binary sum is >9; then add 6 and keep the low 4 bits.
  - Every result digit is always 0..9.
- start while busy=1 is ignored. Operand changes while busy have no effect.

## Timing
- Reset values: busy=0, done=0, result=0, carry_out=0, negative=0, error=0, state=IDLE, index=0, carry=0.
- Reset in any state aborts the operation at that edge. No done pulse follows; all outputs take their reset values.
- Start edge E0 (start=1, busy=0). busy=1 from E0.
- Latency from E0 to the edge that raises done:
  - Add, or non-negative subtract: DIGITS cycles.
  - Negative subtract: 2*DIGITS cycles.
  - Invalid digit: 1 cycle.
- done=1 and busy=0 in the same cycle. A new start may be accepted in that cycle.
- result, carry_out, negative and error:
  - Update digit-by-digit during passes.
  - Only valid when done=1.
  - Hold until the next accepted start.
- Back-to-back operations need no idle cycle beyond the done cycle.

## Test plan
All scenarios use DIGITS=4; operands are shown as decimal digit strings.
- Add 1234+5678 → result 6912, carry_out=0, negative=0; done exactly 4 cycles after the start edge; busy high for those 4 cycles.
- Add 9999+0001 → result 0000, carry_out=1; then add 0000+0000 back-to-back in the done cycle → result 0000, carry_out=0.
- Subtract 5000−1234 → result 3766, negative=0, latency 4. Subtract 0042−0042 → result 0000, negative=0.
- Subtract 1234−5000 → result 3766, negative=1, carry_out=0; done exactly 8 cycles after start.
- Invalid operand a=0x12A4 → error=1, result 0000; done 1 cycle after start. The next valid add clears error.
- Robustness:
  - Pulse start again during PASS1 → ignored; the original result completes unchanged.
  - Assert reset during PASS2 → all outputs 0, busy=0, no done pulse.
  - A fresh start afterwards completes correctly.
